led_ctrl: RTL
=============

# led_ctrl

Mode controller for the board LED bank. It turns raw push-button presses into debounced single-cycle commands and runs a four-state mode machine. It sequences the LED datapath between a switch-select mux, a rotating light, an up/down counter and a switch-blink pattern. It sits between the board inputs (btn, sw) and the ledr outputs, and all pattern stepping is paced by an internal prescaler.

## Interface
- TICK_DIV, 5000000: clk cycles per pattern step; legal range ≥ 2.
- DEB_CYCLES, 100000: consecutive stable cycles required to accept a button level change; legal range ≥ 2.
- clk  input  1  single system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-low reset; rst=0 at a rising edge resets all state.
- btn  input  5  raw buttons, active-high, asynchronous to clk, bouncing. [0]=next mode, [1]=previous mode, [2]=pause/resume, [3]=reverse direction, [4]=clear.
- sw  input  8  raw switches, level inputs, used unsynchronised-to-register.
- ledr  output  16  registered LED drive.
- mode  output  2  registered current mode: 0=MUX, 1=RUN, 2=COUNT, 3=BLINK.

## Operation
- Input sync: each btn bit passes through a 2-flop synchroniser before its debouncer. sw is sampled directly.
- Debounce, per button:
  - A stable level register (reset 0) and a counter are kept.
  - The counter increments each cycle the synchronised input differs from the stable level. It clears whenever they match.
  - When the counter reaches DEB_CYCLES-1 while they still differ, the stable level flips and the counter clears.
  - A 0→1 flip of the stable level produces a one-cycle press pulse. Releases produce no pulse.
- Command priority in a cycle with several pulses:
  - clear beats everything.
  - next+prev together: no mode change; both are ignored.
  - Pause and reverse are applied independently of any mode change in the same cycle.
- Mode FSM: next: mode+1 mod 4 (3→0). prev: mode-1 mod 4 (0→3).
- On a mode change or clear:
  - Prescaler loads 0.
  - Pattern state loads its init value: RUN 16'h0001, COUNT 16'h0000, BLINK phase=on.
  - dir and paused are kept.
- Toggles: pause toggles paused; reverse toggles dir (0=left/up, 1=right/down).
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick is asserted when count==TICK_DIV-1 and not paused.
  - While paused, the count holds.
- Per-mode ledr next value:
  - MUX: {15'b0, sw[2] ? sw[1] : sw[0]}, updated every cycle; ignores tick, pause and dir.
  - RUN: one-hot rotates left on tick (bit15→bit0 wrap) when dir=0, right (bit0→bit15) when dir=1.
  - COUNT: 16-bit value +1 on tick (dir=0) or -1 (dir=1), modulo 2^16. FFFF+1=0000; 0000-1=FFFF.
  - BLINK: phase toggles on tick. ledr={8'h00, sw} when phase=on, 16'h0000 when off. sw is re-sampled every cycle while on.
- Reset (rst=0): mode=0, ledr=16'h0000, dir=0, paused=0, prescaler=0, debouncers stable=0 with counters 0, synchronisers 0, RUN/COUNT/BLINK state at init values.
- Reset asserted mid-pattern or mid-debounce discards all progress. A button still held through reset release needs a full DEB_CYCLES from the synchronised level before it registers.

## Timing
- Button latency: raw btn rising at edge t (stable thereafter) gives synchronised high after edge t+2. The press pulse is high in the cycle after edge t+2+DEB_CYCLES-1. mode/ledr update at the following edge.
- mode changes exactly one edge after the pulse. ledr shows the new mode's init pattern on that same edge: RUN shows 0001 immediately; COUNT shows 0000.
- MUX: ledr[0] follows sw with exactly one cycle of latency.
- Step spacing: TICK_DIV cycles between consecutive pattern steps. The first step after a mode change or clear comes TICK_DIV cycles after that edge.
- Pause takes effect at the edge after its pulse. A tick coinciding with the pause pulse still applies. On resume, the prescaler continues from its held count.
- Reverse coinciding with a tick: the step uses the old dir; the new dir applies from the next tick.
- Clear coinciding with a tick: the init value wins and the tick is discarded.

## Test plan
Run with TICK_DIV=3 and DEB_CYCLES=4.
- Reset: hold rst=0 for 5 cycles with random btn/sw, then release. Required: mode=0 and ledr=0000. sw=8'b0000_0110 gives ledr=0001 one cycle later; sw=8'b0000_0010 gives ledr=0000.
- Debounce: btn[0] bounces 1,0,1,0 per cycle, then holds 1 for 3 cycles. Required: no mode change. Btn[0] then held 10 cycles: mode goes 0→1 exactly once, at edge t+6 after stable rise t. ledr=0001, then 0002 and 0004 every 3 cycles.
- Wrap and reverse in RUN and COUNT: in RUN, reverse at ledr=0001 gives 8000 on the next tick. Press next to COUNT with dir=1: ledr 0000→FFFF→FFFE. Reverse, then ticks give FFFF→0000.
- Pause: in COUNT at 0005, press pause. Required: ledr holds 0005 for 20 cycles. Press pause again: 0006 appears after the remaining prescaler count completes.
- Simultaneous commands: next+prev in the same pulse cycle leaves mode unchanged. clear+tick in COUNT at 0009 gives 0000. prev from mode 0 gives mode=3 (BLINK), with ledr alternating {00,sw} and 0000 every 3 cycles.
- Reset mid-operation: in BLINK, paused, dir=1, assert rst=0 for one edge. Required: all outputs and state return to reset values, and the pattern restarts from MUX.

Source files
------------

// File: rtl/led_ctrl.sv
// ---------------------------------------------------------------------------
// led_ctrl
//
// Mode controller for the board LED bank. Raw push buttons are synchronised,
// debounced and turned into single-cycle press commands. These commands drive
// a four-state mode machine that selects what the LED bank shows:
//   MUX   : ledr[0] is a switch-selected bit, refreshed every cycle
//   RUN   : a rotating one-hot light
//   COUNT : a 16-bit up/down counter
//   BLINK : the switch byte, blinking on and off
// Pattern stepping is paced by an internal prescaler. That prescaler can be
// paused, and the step direction can be reversed.
//
// Parameters
//   TICK_DIV   : clk cycles per pattern step (>= 2)
//   DEB_CYCLES : consecutive stable cycles needed to accept a button change (>= 2)
//
// Ports
//   clk  : system clock, all state changes on the rising edge
//   rst  : synchronous, active-low reset
//   btn  : raw buttons, active-high, bouncing, asynchronous to clk
//          [0]=next mode, [1]=previous mode, [2]=pause/resume,
//          [3]=reverse direction, [4]=clear
//   sw   : switch levels, used directly without synchronisation
//   ledr : registered LED drive
//   mode : registered current mode (0=MUX, 1=RUN, 2=COUNT, 3=BLINK)
// ---------------------------------------------------------------------------
module led_ctrl #(
  parameter int TICK_DIV   = 5000000,
  parameter int DEB_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  btn,
  input  logic [7:0]  sw,
  output logic [15:0] ledr,
  output logic [1:0]  mode
);

  // -------------------------------------------------------------------------
  // Constants
  // -------------------------------------------------------------------------
  localparam int N_BTN = 5;

  localparam int BTN_NEXT  = 0;
  localparam int BTN_PREV  = 1;
  localparam int BTN_PAUSE = 2;
  localparam int BTN_REV   = 3;
  localparam int BTN_CLEAR = 4;

  localparam int DEB_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam int PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  localparam logic [1:0] MODE_MUX   = 2'd0;
  localparam logic [1:0] MODE_RUN   = 2'd1;
  localparam logic [1:0] MODE_COUNT = 2'd2;
  localparam logic [1:0] MODE_BLINK = 2'd3;

  localparam logic [15:0] RUN_INIT   = 16'h0001;
  localparam logic [15:0] CNT_INIT   = 16'h0000;
  localparam logic        PHASE_INIT = 1'b1;    // BLINK starts in the "on" phase

  // -------------------------------------------------------------------------
  // Button synchronisers (two flops per bit)
  // -------------------------------------------------------------------------
  logic [N_BTN-1:0] sync1_q;
  logic [N_BTN-1:0] sync2_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

  // -------------------------------------------------------------------------
  // Debouncers, one per button
  //
  // The counter tracks how long the synchronised input has disagreed with the
  // accepted level. When it has disagreed with the counter already at
  // DEB_CYCLES-1, the accepted level flips on this edge. The press pulse is
  // raised combinationally in that same cycle, but only for a 0->1 flip. A
  // command therefore takes effect on exactly the edge where the level is
  // accepted.
  // -------------------------------------------------------------------------
  logic [N_BTN-1:0] press;

  generate
    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_deb
      logic [DEB_W-1:0] cnt_q;
      logic [DEB_W-1:0] cnt_d;
      logic             stable_q;
      logic             stable_d;
      logic             differ;
      logic             expire;

      always_comb begin
        differ   = sync2_q[gi] ^ stable_q;
        expire   = differ && (cnt_q == DEB_LAST);
        stable_d = stable_q;
        cnt_d    = '0;
        if (expire) begin
          stable_d = ~stable_q;
        end else if (differ) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Only the accepted rising level is a press; releases are silent.
      assign press[gi] = expire & sync2_q[gi];

      always_ff @(posedge clk) begin
        if (!rst) begin
          cnt_q    <= '0;
          stable_q <= 1'b0;
        end else begin
          cnt_q    <= cnt_d;
          stable_q <= stable_d;
        end
      end
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Command decode
  //
  // Clear overrides every other button in the same cycle. Next and prev
  // pressed together cancel out. Pause and reverse otherwise act independently
  // of a mode change.
  // -------------------------------------------------------------------------
  logic cmd_clear;
  logic cmd_next;
  logic cmd_prev;
  logic cmd_pause;
  logic cmd_rev;
  logic restart;      // pattern and prescaler go back to their init values

  always_comb begin
    cmd_clear = press[BTN_CLEAR];
    cmd_next  = !cmd_clear && press[BTN_NEXT] && !press[BTN_PREV];
    cmd_prev  = !cmd_clear && press[BTN_PREV] && !press[BTN_NEXT];
    cmd_pause = !cmd_clear && press[BTN_PAUSE];
    cmd_rev   = !cmd_clear && press[BTN_REV];
    restart   = cmd_clear || cmd_next || cmd_prev;
  end

  // -------------------------------------------------------------------------
  // Control state: mode, direction, pause, prescaler
  // -------------------------------------------------------------------------
  logic [1:0]       mode_q;
  logic [1:0]       mode_d;
  logic             dir_q;      // 0 = left/up, 1 = right/down
  logic             dir_d;
  logic             paused_q;
  logic             paused_d;
  logic [PRE_W-1:0] pre_q;
  logic [PRE_W-1:0] pre_d;
  logic             tick;

  always_comb begin
    mode_d = mode_q;
    if (cmd_next) begin
      mode_d = mode_q + 2'd1;       // 3 -> 0 by natural wrap
    end else if (cmd_prev) begin
      mode_d = mode_q - 2'd1;       // 0 -> 3 by natural wrap
    end
  end

  always_comb begin
    dir_d    = dir_q ^ cmd_rev;
    paused_d = paused_q ^ cmd_pause;
  end

  // The tick uses the current paused state. A tick that lands in the same
  // cycle as a pause press therefore still steps the pattern.
  assign tick = (pre_q == PRE_LAST) && !paused_q;

  always_comb begin
    pre_d = pre_q;
    if (restart) begin
      pre_d = '0;
    end else if (!paused_q) begin
      pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mode_q   <= MODE_MUX;
      dir_q    <= 1'b0;
      paused_q <= 1'b0;
      pre_q    <= '0;
    end else begin
      mode_q   <= mode_d;
      dir_q    <= dir_d;
      paused_q <= paused_d;
      pre_q    <= pre_d;
    end
  end

  // -------------------------------------------------------------------------
  // Pattern state
  //
  // Each pattern keeps its own register, and only the active mode's register
  // steps on a tick. A restart reloads all of them. Steps use the current
  // dir_q, so a reverse press that lands on a tick takes effect from the
  // following tick. A restart outranks a tick, so the init value wins.
  // -------------------------------------------------------------------------
  logic [15:0] run_q;
  logic [15:0] run_d;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic        phase_q;
  logic        phase_d;

  always_comb begin
    run_d = run_q;
    if (restart) begin
      run_d = RUN_INIT;
    end else if (tick && (mode_q == MODE_RUN)) begin
      run_d = dir_q ? {run_q[0], run_q[15:1]}     // right: bit0 wraps to bit15
                    : {run_q[14:0], run_q[15]};   // left: bit15 wraps to bit0
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = CNT_INIT;
    end else if (tick && (mode_q == MODE_COUNT)) begin
      cnt_d = dir_q ? cnt_q - 16'd1 : cnt_q + 16'd1;
    end
  end

  always_comb begin
    phase_d = phase_q;
    if (restart) begin
      phase_d = PHASE_INIT;
    end else if (tick && (mode_q == MODE_BLINK)) begin
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      run_q   <= RUN_INIT;
      cnt_q   <= CNT_INIT;
      phase_q <= PHASE_INIT;
    end else begin
      run_q   <= run_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  // -------------------------------------------------------------------------
  // LED output register
  //
  // The output is built from the next mode and the next pattern state. A
  // mode change therefore shows the new mode's init pattern on the same edge.
  // -------------------------------------------------------------------------
  logic [15:0] ledr_q;
  logic [15:0] ledr_d;

  always_comb begin
    case (mode_d)
      MODE_MUX:   ledr_d = {15'b0, (sw[2] ? sw[1] : sw[0])};
      MODE_RUN:   ledr_d = run_d;
      MODE_COUNT: ledr_d = cnt_d;
      default:    ledr_d = phase_d ? {8'h00, sw} : 16'h0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ledr_q <= 16'h0000;
    end else begin
      ledr_q <= ledr_d;
    end
  end

  assign ledr = ledr_q;
  assign mode = mode_q;

endmodule
